rob_scheduler: RTL
==================

ROB_SCHEDULER -- requirements
Module: rob_scheduler

Interface
REQ-001: Parameter ROB_DEPTH, default 8, number of reorder-buffer entries; power of two, at least 2.
REQ-002: Parameter NUM_WALKERS, default 2, number of completion requesters (PLB/walking stages), at least 1.
REQ-003: Parameter DATA_WIDTH, default 32, completion payload width.
REQ-004: Derived ID_WIDTH = $clog2(ROB_DEPTH).
REQ-005: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006: rst_i  input  1  reset, synchronous, active-high.
REQ-007: flush_i  input  1  synchronous clear of all in-flight transactions.
REQ-008: alloc_valid_i  input  1  issue stage requests a transaction ID.
REQ-009: alloc_ready_o  output  1  an ID is available.
REQ-010: alloc_id_o  output  ID_WIDTH  ID granted on the alloc handshake.
REQ-011: cmpl_valid_i  input  NUM_WALKERS  per-walker completion request.
REQ-012: cmpl_id_i  input  NUM_WALKERS*ID_WIDTH  per-walker completed ID; walker i uses slice [i*ID_WIDTH +: ID_WIDTH].
REQ-013: cmpl_data_i  input  NUM_WALKERS*DATA_WIDTH  per-walker result payload, sliced the same way.
REQ-014: cmpl_ready_o  output  NUM_WALKERS  one-hot grant; completion i is accepted when cmpl_valid_i[i] and cmpl_ready_o[i] are both high.
REQ-015: commit_valid_o  output  1  the head transaction is complete.
REQ-016: commit_ready_i  input  1  commit stage accepts the head.
REQ-017: commit_id_o, commit_data_o  output  ID_WIDTH, DATA_WIDTH  head ID and its stored payload.
REQ-018: count_o  output  ID_WIDTH+1  number of allocated, uncommitted entries.
REQ-019: err_o  output  1  sticky flag: a completion targeted a non-allocated or already-done ID.

Function
REQ-020: The block shall hold head and tail pointers of ID_WIDTH+1 bits (wrap bit), plus per-entry alloc bit, done bit and DATA_WIDTH payload register.
REQ-021: alloc_ready_o = (count_o < ROB_DEPTH), combinational from registered state only, with no bypass from a same-cycle commit; alloc_id_o = tail[ID_WIDTH-1:0].
REQ-022: Alloc handshake: set alloc[tail], clear done[tail], increment tail modulo 2*ROB_DEPTH.
REQ-023: Completion arbitration: round-robin, at most one grant per cycle, and only among asserted cmpl_valid_i; cmpl_ready_o is all-zero when no request is valid.
REQ-024: The round-robin pointer advances to grantee+1 (mod NUM_WALKERS) after each accepted grant and holds otherwise; at reset it gives walker 0 highest priority.
REQ-025: Accepted completion to an ID with alloc=1 and done=0: set done and write the payload; the result is visible the next cycle.
REQ-026: Accepted completion to an ID with alloc=0 or done=1: no state change and set err_o. This includes an ID allocated in the same cycle.
REQ-027: commit_valid_o = (count_o != 0) && done[head]; commit_id_o and commit_data_o are driven from the head entry.
REQ-028: Commit handshake: clear alloc[head] and done[head], increment head.
REQ-029: count_o = tail - head (ID_WIDTH+1 bits); simultaneous alloc and commit leave it unchanged.
REQ-030: Latencies: alloc at cycle N allows completion at N+1 earliest; completion at N drives commit_valid_o at N+1 earliest.
REQ-031: commit_valid_o, once high, shall stay high with stable ID and data until the handshake occurs or a flush is applied.
REQ-032: Flush: clear head, tail, all alloc and done bits and the RR pointer; all handshakes in the flush cycle are discarded; err_o is kept.
REQ-033: Priority order: rst_i, then flush_i, then normal operation. Alloc, completion and commit in the same cycle update independent state and shall all take effect.

Reset
REQ-034: When rst_i is high at a clock edge, the block shall clear head, tail, alloc, done, RR pointer and err_o.
REQ-035: Output values after reset: alloc_ready_o=1, alloc_id_o=0, cmpl_ready_o=0, commit_valid_o=0, count_o=0, err_o=0. Payload registers need no reset.
REQ-036: Reset applied mid-operation shall discard every in-flight transaction in the same edge; no commit handshake shall be reported afterwards.

Verification (ROB_DEPTH=4, NUM_WALKERS=2)
REQ-037: Fill and wrap: 4 allocs, then alloc_valid_i held -> IDs 0,1,2,3, alloc_ready_o=0, count_o=4. Complete and commit ID 0, then alloc -> ID 0 reissued, count_o=4.
REQ-038: Out-of-order completion: complete IDs 2 then 1 -> commit_valid_o=0; complete ID 0 -> commits of 0,1,2 follow in order with matching payloads.
REQ-039: Arbitration: both walkers valid continuously with distinct allocated IDs -> grants alternate 0,1,0,1; a single requester receives a grant every cycle.
REQ-040: Backpressure: head done and commit_ready_i=0 for 3 cycles -> commit_valid_o, commit_id_o and commit_data_o stay stable; the pop happens on the ready cycle.
REQ-041: Errors: completion to a free ID, then a second completion to a done ID -> err_o=1 from the next cycle and sticky; no alloc or done bit changes.
REQ-042: Flush with 3 in flight plus a same-cycle alloc and completion -> count_o=0, commit_valid_o=0 and alloc_id_o=0 the next cycle.

Source files
------------

// File: rtl/rob_scheduler.sv
// Reorder-buffer scheduler: issues transaction IDs in order, accepts
// out-of-order completions from several walkers through a round-robin
// arbiter, and retires entries strictly in allocation order.
module rob_scheduler #(
    parameter  int ROB_DEPTH   = 8,
    parameter  int NUM_WALKERS = 2,
    parameter  int DATA_WIDTH  = 32,
    localparam int ID_WIDTH    = $clog2(ROB_DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              alloc_valid_i,
    output logic                              alloc_ready_o,
    output logic [ID_WIDTH-1:0]               alloc_id_o,
    input  logic [NUM_WALKERS-1:0]            cmpl_valid_i,
    input  logic [NUM_WALKERS*ID_WIDTH-1:0]   cmpl_id_i,
    input  logic [NUM_WALKERS*DATA_WIDTH-1:0] cmpl_data_i,
    output logic [NUM_WALKERS-1:0]            cmpl_ready_o,
    output logic                              commit_valid_o,
    input  logic                              commit_ready_i,
    output logic [ID_WIDTH-1:0]               commit_id_o,
    output logic [DATA_WIDTH-1:0]             commit_data_o,
    output logic [ID_WIDTH:0]                 count_o,
    output logic                              err_o
);
    localparam int RR_W = (NUM_WALKERS > 1) ? $clog2(NUM_WALKERS) : 1;

    logic [ID_WIDTH:0]                      head_q, head_d, tail_q, tail_d;
    logic [ROB_DEPTH-1:0]                   alloc_q, alloc_d, done_q, done_d;
    logic [ROB_DEPTH-1:0][DATA_WIDTH-1:0]   data_q, data_d;
    logic [RR_W-1:0]                        rr_q, rr_d;
    logic                                   err_q, err_d;

    logic [ID_WIDTH-1:0]   head_idx, tail_idx, gnt_id;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_any, alloc_fire, commit_fire;
    int                    gnt_idx;

    assign head_idx       = head_q[ID_WIDTH-1:0];
    assign tail_idx       = tail_q[ID_WIDTH-1:0];
    assign count_o        = tail_q - head_q;
    // Full check uses registered state only; a same-cycle commit does not free a slot early.
    assign alloc_ready_o  = (count_o < (ID_WIDTH+1)'(ROB_DEPTH));
    assign alloc_id_o     = tail_idx;
    assign commit_valid_o = (count_o != '0) && done_q[head_idx];
    assign commit_id_o    = head_idx;
    assign commit_data_o  = data_q[head_idx];
    assign err_o          = err_q;
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;
    assign commit_fire    = commit_valid_o && commit_ready_i;

    // Round-robin pick: scan walkers starting at rr_q, first valid requester wins.
    always_comb begin
        int idx;
        cmpl_ready_o = '0;
        gnt_any      = 1'b0;
        gnt_idx      = 0;
        for (int k = 0; k < NUM_WALKERS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_WALKERS) idx = idx - NUM_WALKERS;
            if (!gnt_any && cmpl_valid_i[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_any) cmpl_ready_o[gnt_idx] = 1'b1;
        gnt_id   = cmpl_id_i[gnt_idx*ID_WIDTH +: ID_WIDTH];
        gnt_data = cmpl_data_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next state: alloc, completion and commit touch independent entries; flush wipes tracking.
    always_comb begin
        int nxt;
        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        data_d  = data_q;
        rr_d    = rr_q;
        err_d   = err_q;
        nxt     = gnt_idx + 1;
        if (nxt >= NUM_WALKERS) nxt = 0;

        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + (ID_WIDTH+1)'(1);
        end
        if (gnt_any) begin
            rr_d = RR_W'(nxt);
            // Validity is judged on registered bits, so an ID issued this cycle is still free.
            if (alloc_q[gnt_id] && !done_q[gnt_id]) begin
                done_d[gnt_id] = 1'b1;
                data_d[gnt_id] = gnt_data;
            end else begin
                err_d = 1'b1;
            end
        end
        if (commit_fire) begin
            alloc_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + (ID_WIDTH+1)'(1);
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            alloc_d = '0;
            done_d  = '0;
            rr_d    = '0;
            data_d  = data_q;
            err_d   = err_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Payload storage; only read behind a done bit, so it needs no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

endmodule
